mma_tile_scheduler: RTL

// Sequences a tiled GEMM D = A*B + C over the matrix_multiplication_accumulation (MMA) unit.

---
 rtl/mma_tile_scheduler.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mma_tile_scheduler.sv
// Tile scheduler for a tiled GEMM D = A*B + C on a single MMA unit.
// Walks output tiles (m, n) with K-steps innermost and keeps exactly one MMA op in flight.
module mma_tile_scheduler #(
    parameter int CNT_W = 8,
    parameter int MODE  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] m_tiles_i,
    input  logic [CNT_W-1:0] n_tiles_i,
    input  logic [CNT_W-1:0] k_tiles_i,
    input  logic [3:0]       bit_size_a_i,
    input  logic [3:0]       bit_size_b_i,
    input  logic [1:0]       halved_prec_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] op_m_o,
    output logic [CNT_W-1:0] op_n_o,
    output logic [CNT_W-1:0] op_k_o,
    output logic             acc_sel_o,
    output logic             mma_valid_o,
    input  logic             mma_ready_i,
    input  logic             mma_valid_i,
    output logic             mma_ready_o,
    output logic [3:0]       bit_size_a_o,
    output logic [3:0]       bit_size_b_o,
    output logic [1:0]       halved_prec_o,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic             wb_last_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] m_tiles_q, m_tiles_d;
    logic [CNT_W-1:0] n_tiles_q, n_tiles_d;
    logic [CNT_W-1:0] k_tiles_q, k_tiles_d;
    logic [CNT_W-1:0] m_q, m_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [3:0]       bsa_q, bsa_d;
    logic [3:0]       bsb_q, bsb_d;
    logic [1:0]       hp_q, hp_d;
    logic             err_q, err_d;

    logic cfg_bad;
    logic cnt_zero;
    logic last_k;
    logic last_m;
    logic last_n;

    assign cfg_bad  = (MODE == 2) &&
                      ((bit_size_a_i == 4'd0) || (bit_size_a_i > 4'd7) ||
                       (bit_size_b_i == 4'd0) || (bit_size_b_i > 4'd7));
    assign cnt_zero = (m_tiles_i == '0) || (n_tiles_i == '0) || (k_tiles_i == '0);

    // Latched counts are nonzero whenever ISSUE/WAIT is reachable, so "-1" cannot wrap there.
    assign last_k = (k_q == k_tiles_q - ONE);
    assign last_m = (m_q == m_tiles_q - ONE);
    assign last_n = (n_q == n_tiles_q - ONE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            m_tiles_q <= '0;
            n_tiles_q <= '0;
            k_tiles_q <= '0;
            m_q       <= '0;
            n_q       <= '0;
            k_q       <= '0;
            bsa_q     <= '0;
            bsb_q     <= '0;
            hp_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_tiles_q <= m_tiles_d;
            n_tiles_q <= n_tiles_d;
            k_tiles_q <= k_tiles_d;
            m_q       <= m_d;
            n_q       <= n_d;
            k_q       <= k_d;
            bsa_q     <= bsa_d;
            bsb_q     <= bsb_d;
            hp_q      <= hp_d;
            err_q     <= err_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        m_tiles_d   = m_tiles_q;
        n_tiles_d   = n_tiles_q;
        k_tiles_d   = k_tiles_q;
        m_d         = m_q;
        n_d         = n_q;
        k_d         = k_q;
        bsa_d       = bsa_q;
        bsb_d       = bsb_q;
        hp_d        = hp_q;
        err_d       = 1'b0;
        mma_valid_o = 1'b0;
        mma_ready_o = 1'b0;
        wb_valid_o  = 1'b0;
        wb_last_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    m_tiles_d = m_tiles_i;
                    n_tiles_d = n_tiles_i;
                    k_tiles_d = k_tiles_i;
                    bsa_d     = bit_size_a_i;
                    bsb_d     = bit_size_b_i;
                    hp_d      = halved_prec_i;
                    m_d       = '0;
                    n_d       = '0;
                    k_d       = '0;
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else if (cnt_zero) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                mma_valid_o = 1'b1;
                if (mma_ready_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (!last_k) begin
                    mma_ready_o = 1'b1;
                    if (mma_valid_i) begin
                        k_d     = k_q + ONE;
                        state_d = S_ISSUE;
                    end
                end else begin
                    // Final K-step: the MMA output bus goes straight to writeback, no local copy.
                    wb_valid_o  = mma_valid_i;
                    mma_ready_o = wb_ready_i;
                    wb_last_o   = mma_valid_i && last_m && last_n;
                    if (mma_valid_i && wb_ready_i) begin
                        k_d     = '0;
                        state_d = S_ISSUE;
                        if (last_n) begin
                            n_d = '0;
                            if (last_m) begin
                                m_d     = '0;
                                state_d = S_DONE;
                            end else begin
                                m_d = m_q + ONE;
                            end
                        end else begin
                            n_d = n_q + ONE;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = err_q;
    assign op_m_o        = m_q;
    assign op_n_o        = n_q;
    assign op_k_o        = k_q;
    assign acc_sel_o     = (k_q != '0);
    assign bit_size_a_o  = (MODE == 2) ? bsa_q : 4'd0;
    assign bit_size_b_o  = (MODE == 2) ? bsb_q : 4'd0;
    assign halved_prec_o = (MODE == 1) ? hp_q : 2'd0;

endmodule
